ddfs_frequency_decoder: RTL and testbench

DDFS_FREQUENCY_DECODER -- requirements
Module: ddfs_frequency_decoder

---
 rtl/ddfs_frequency_decoder.sv | 147 ++++++++++++++
 tb/tb_ddfs_frequency_decoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ddfs_frequency_decoder.sv
// Reconstructs a DDFS output frequency from its frequency word and clock-divider select
// using a sequential shift-add multiply. Optional macro DDFS_DECODER_ROUND_EN: round half up.
module ddfs_frequency_decoder #(
   parameter logic [63:0] CLK_FREQ = 64'd200000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  fw,
   input  logic [2:0]  freq_control,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] freq,
   output logic        err,
   output logic        sat,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

   localparam logic [63:0] K_DIV2   = CLK_FREQ / 64'd2;
   localparam logic [63:0] K_DIV10  = CLK_FREQ / 64'd10;
   localparam logic [63:0] K_DIV1E2 = CLK_FREQ / 64'd100;
   localparam logic [63:0] K_DIV1E3 = CLK_FREQ / 64'd1000;
   localparam logic [63:0] K_DIV1E4 = CLK_FREQ / 64'd10000;
   localparam logic [63:0] K_DIV1E5 = CLK_FREQ / 64'd100000;
   localparam logic [63:0] K_DIV1E6 = CLK_FREQ / 64'd1000000;

`ifdef DDFS_DECODER_ROUND_EN
   localparam logic [71:0] ROUND_ADD = 72'd512;
`else
   localparam logic [71:0] ROUND_ADD = 72'd0;
`endif

   state_t      state_q, state_d;
   logic [7:0]  step_q, step_d;
   logic [63:0] const_q, const_d;
   logic [71:0] acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] freq_q, freq_d;
   logic        err_q, err_d;
   logic        sat_q, sat_d;
   logic        out_valid_q, out_valid_d;
   logic [71:0] norm_sum;
   logic [71:0] norm_shift;
   logic [63:0] sel_const;

   always_comb begin
      sel_const = 64'd0;
      case (freq_control)
         3'd0:    sel_const = K_DIV2;
         3'd1:    sel_const = K_DIV10;
         3'd2:    sel_const = K_DIV1E2;
         3'd3:    sel_const = K_DIV1E3;
         3'd4:    sel_const = K_DIV1E4;
         3'd5:    sel_const = K_DIV1E5;
         3'd6:    sel_const = K_DIV1E6;
         default: sel_const = 64'd0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      const_d    = const_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      freq_d     = freq_q;
      err_d      = err_q;
      sat_d      = sat_q;
      norm_sum   = acc_q + ROUND_ADD;
      norm_shift = norm_sum >> 10;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               err_d = 1'b0;
               sat_d = 1'b0;
               if (freq_control == 3'd7) begin
                  freq_d  = 32'd0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  step_d  = {1'b0, fw} + 8'd1;
                  const_d = sel_const;
                  acc_d   = 72'd0;
                  cnt_d   = 3'd0;
                  state_d = MUL;
               end
            end
         end
         MUL: begin
            if (step_q[cnt_q])
               acc_d = acc_q + ({8'd0, const_q} << cnt_q);
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7)
               state_d = NORM;
         end
         NORM: begin
            if (|norm_shift[71:32]) begin
               freq_d = 32'hFFFF_FFFF;
               sat_d  = 1'b1;
            end else begin
               freq_d = norm_shift[31:0];
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_valid_q && out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // The error path enters DONE straight from IDLE, so valid waits one extra cycle there
      out_valid_d = (state_d == DONE) && (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         step_q      <= 8'd0;
         const_q     <= 64'd0;
         acc_q       <= 72'd0;
         cnt_q       <= 3'd0;
         freq_q      <= 32'd0;
         err_q       <= 1'b0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         const_q     <= const_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         freq_q      <= freq_d;
         err_q       <= err_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign freq      = freq_q;
   assign err       = err_q;
   assign sat       = sat_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ddfs_frequency_decoder.sv
// Directed self-checking bench for ddfs_frequency_decoder, with a second instance
// at a very high clock frequency so the saturation path is reachable.
module tb_ddfs_frequency_decoder;

   logic        clk;
   logic        rst_n;
   logic [6:0]  fw;
   logic [2:0]  freq_control;
   logic        in_valid;
   logic        out_ready;
   logic        in_ready, err, sat, out_valid;
   logic [31:0] freq;
   logic        in_ready_big, err_big, sat_big, out_valid_big;
   logic [31:0] freq_big;

   int checks_total  = 0;
   int checks_passed = 0;

`ifdef DDFS_DECODER_ROUND_EN
   localparam logic [31:0] EXP_FW20 = 32'd4102;
`else
   localparam logic [31:0] EXP_FW20 = 32'd4101;
`endif

   ddfs_frequency_decoder #(.CLK_FREQ(64'd200000000)) dut (
      .clk(clk), .rst_n(rst_n), .fw(fw), .freq_control(freq_control),
      .in_valid(in_valid), .in_ready(in_ready), .freq(freq), .err(err),
      .sat(sat), .out_valid(out_valid), .out_ready(out_ready)
   );

   ddfs_frequency_decoder #(.CLK_FREQ(64'd1 << 40)) dut_big (
      .clk(clk), .rst_n(rst_n), .fw(fw), .freq_control(freq_control),
      .in_valid(in_valid), .in_ready(in_ready_big), .freq(freq_big), .err(err_big),
      .sat(sat_big), .out_valid(out_valid_big), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
   endtask

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and measures edges until out_valid, counting the acceptance edge as 1
   task automatic applyStimulus(input string tag, input logic [6:0] f, input logic [2:0] c,
                                input int expLat, input logic [31:0] expFreq,
                                input logic expErr, input logic expSat);
      int edges;
      checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd1);
      fw = f;
      freq_control = c;
      in_valid = 1'b1;
      stepEdge();
      in_valid = 1'b0;
      fw = ~f;
      freq_control = 3'd5;
      edges = 1;
      while (!out_valid && edges < 40) begin
         stepEdge();
         edges++;
      end
      checkOutput({tag, " latency"}, 64'(edges), 64'(expLat));
      checkOutput({tag, " freq"}, 64'(freq), 64'(expFreq));
      checkOutput({tag, " err"}, 64'(err), 64'(expErr));
      checkOutput({tag, " sat"}, 64'(sat), 64'(expSat));
   endtask

   task automatic releaseResult(input string tag);
      out_ready = 1'b1;
      stepEdge();
      out_ready = 1'b0;
      checkOutput({tag, " valid dropped"}, 64'(out_valid), 64'd0);
      checkOutput({tag, " in_ready back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic stable;
      logic [31:0] held;
      rst_n = 1'b0;
      fw = 7'd0;
      freq_control = 3'd0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #22;
      checkOutput("reset freq", 64'(freq), 64'd0);
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset err", 64'(err), 64'd0);
      checkOutput("reset sat", 64'(sat), 64'd0);
      rst_n = 1'b1;
      #2;

      applyStimulus("fw127 fc0", 7'd127, 3'd0, 10, 32'd12500000, 1'b0, 1'b0);
      checkOutput("big fw127 sat", 64'(sat_big), 64'd1);
      checkOutput("big fw127 freq", 64'(freq_big), 64'hFFFF_FFFF);
      releaseResult("fw127 fc0");

      applyStimulus("fw20 fc3", 7'd20, 3'd3, 10, EXP_FW20, 1'b0, 1'b0);
      checkOutput("big fw20 sat", 64'(sat_big), 64'd0);
      checkOutput("big fw20 freq", 64'(freq_big), 64'd22548578);
      releaseResult("fw20 fc3");

      applyStimulus("fw50 fc2", 7'd50, 3'd2, 10, 32'd99609, 1'b0, 1'b0);
      releaseResult("fw50 fc2");
      applyStimulus("fw0 fc6", 7'd0, 3'd6, 10, 32'd0, 1'b0, 1'b0);
      releaseResult("fw0 fc6");

      applyStimulus("fc7 err", 7'd10, 3'd7, 2, 32'd0, 1'b1, 1'b0);
      releaseResult("fc7 err");
      applyStimulus("after err", 7'd127, 3'd0, 10, 32'd12500000, 1'b0, 1'b0);
      releaseResult("after err");

      // Result held back by the consumer while a competing request is offered
      applyStimulus("stall", 7'd50, 3'd2, 10, 32'd99609, 1'b0, 1'b0);
      held = freq;
      stable = 1'b1;
      fw = 7'd3;
      freq_control = 3'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         stepEdge();
         if (freq !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0) stable = 1'b0;
      end
      checkOutput("stall stable", 64'(stable), 64'd1);
      in_valid = 1'b0;
      releaseResult("stall");
      stepEdge();
      checkOutput("stall no ghost request", 64'(in_ready), 64'd1);

      // Reset asserted asynchronously during the fourth multiply iteration
      fw = 7'd127;
      freq_control = 3'd0;
      in_valid = 1'b1;
      stepEdge();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) stepEdge();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midmul reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("midmul reset freq", 64'(freq), 64'd0);
      checkOutput("midmul reset in_ready", 64'(in_ready), 64'd1);
      #4;
      rst_n = 1'b1;
      applyStimulus("post reset", 7'd127, 3'd1, 10, 32'd2500000, 1'b0, 1'b0);
      checkOutput("big post reset sat", 64'(sat_big), 64'd1);
      releaseResult("post reset");

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
